// File: rtl/blk_613df0.sv
// blk_613df0: multi-controller MBIST diagnosis-ready SIB/TDR.
// Combines NUM_CTL masked controller ready flags with an auxiliary ready,
// then synchronizes and stability-filters the result in the clk domain to
// drive StableBlock. The TDR also holds a filter-bypass bit that restores
// the legacy combinational behaviour.
//
// IJTAG segment: si -> [tdr[NUM_CTL] .. tdr[0]] -> sib -> so, with the TDR
// part only in the path while sib_latch is 1.
// TDR layout: tdr[NUM_CTL-1:0] = controller mask (1 = participates),
//             tdr[NUM_CTL]     = filter bypass.
module blk_613df0 #(
   parameter int NUM_CTL        = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 8,
   parameter int CAPTURE_STATUS = 1
) (
   input  logic               ijtag_tck,
   input  logic               clk,
   input  logic               ijtag_reset,
   input  logic               ijtag_sel,
   input  logic               ijtag_si,
   input  logic               ijtag_ce,
   input  logic               ijtag_se,
   input  logic               ijtag_ue,
   output logic               ijtag_so,
   input  logic [NUM_CTL-1:0] DiagnosisReady_ctl_in,
   input  logic               DiagnosisReady_aux_in,
   output logic               StableBlock
);

   // Counter is at least one bit wide so STABLE_CYCLES=0 still elaborates;
   // in that case it simply stays at zero and the filter is transparent.
   localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   logic [NUM_CTL:0]     tdr;
   logic [NUM_CTL:0]     tdr_nr;
   logic                 sib;
   logic                 sib_latch;
   logic                 so_q;
   logic                 tdr_select;
   logic                 raw;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 sync_out;
   logic [CNT_W-1:0]     cnt;
   logic                 filt;

   assign tdr_select = ijtag_sel & sib_latch;

   // TDR shift/capture stage: capture has priority over shift.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         tdr <= '0;
      end else if (tdr_select) begin
         if (ijtag_ce) begin
            if (CAPTURE_STATUS != 0) begin
               tdr <= {tdr_nr[NUM_CTL], DiagnosisReady_ctl_in};
            end else begin
               tdr <= '0;
            end
         end else if (ijtag_se) begin
            tdr <= {ijtag_si, tdr[NUM_CTL:1]};
         end
      end
   end

   // SIB shift/capture bit: captures the filtered ready, shifts from the
   // TDR tail when the segment is open, otherwise straight from si.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         sib <= 1'b0;
      end else if (ijtag_sel) begin
         if (ijtag_ce) begin
            sib <= StableBlock;
         end else if (ijtag_se) begin
            sib <= sib_latch ? tdr[0] : ijtag_si;
         end
      end
   end

   // Update stage on falling tck: SIB open/close and TDR shadow register.
   always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         sib_latch <= 1'b0;
         tdr_nr    <= '0;
      end else if (ijtag_ue) begin
         if (ijtag_sel) begin
            sib_latch <= sib;
         end
         if (tdr_select) begin
            tdr_nr <= tdr;
         end
      end
   end

   // Scan-out retiming on tck low. sib only changes on rising tck, so a
   // falling-edge flop gives the same output as a transparent-low latch.
   always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         so_q <= 1'b0;
      end else begin
         so_q <= sib;
      end
   end

   assign ijtag_so = so_q;

   // Combined ready: a masked-out controller never blocks readiness.
   assign raw = DiagnosisReady_aux_in &
                (&(~tdr_nr[NUM_CTL-1:0] | DiagnosisReady_ctl_in));

   // Synchronizer chain bringing raw into the clk domain.
   always_ff @(posedge clk or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Stability counter: clears whenever synced ready drops, saturates at max.
   always_ff @(posedge clk or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         cnt <= '0;
      end else if (!sync_out) begin
         cnt <= '0;
      end else if (cnt < CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Filter output is built only from flops, so it cannot glitch on raw.
   assign filt = sync_out & (cnt == CNT_MAX);

   assign StableBlock = tdr_nr[NUM_CTL] ? raw : filt;

endmodule

// File: tb/tb_blk_613df0.sv
// Directed bench for blk_613df0 (NUM_CTL=4, SYNC_STAGES=2, STABLE_CYCLES=8,
// CAPTURE_STATUS=1). Stimulus pushes expected values into exp_q; a monitor
// process pops them against observed DUT values on each clk falling edge.
module tb_blk_613df0;

   localparam int W = 16;

   logic       ijtag_tck;
   logic       clk;
   logic       ijtag_reset;
   logic       ijtag_sel;
   logic       ijtag_si;
   logic       ijtag_ce;
   logic       ijtag_se;
   logic       ijtag_ue;
   logic       ijtag_so;
   logic [3:0] ctl;
   logic       aux;
   logic       StableBlock;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] act_q[$];
   string        name_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;

   logic [W-1:0] mon_e;
   logic [W-1:0] mon_a;
   string        mon_n;

   blk_613df0 #(
      .NUM_CTL(4),
      .SYNC_STAGES(2),
      .STABLE_CYCLES(8),
      .CAPTURE_STATUS(1)
   ) dut (
      .ijtag_tck(ijtag_tck),
      .clk(clk),
      .ijtag_reset(ijtag_reset),
      .ijtag_sel(ijtag_sel),
      .ijtag_si(ijtag_si),
      .ijtag_ce(ijtag_ce),
      .ijtag_se(ijtag_se),
      .ijtag_ue(ijtag_ue),
      .ijtag_so(ijtag_so),
      .DiagnosisReady_ctl_in(ctl),
      .DiagnosisReady_aux_in(aux),
      .StableBlock(StableBlock)
   );

   // clock block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      ijtag_tck = 1'b0;
      #3;
      forever #20 ijtag_tck = ~ijtag_tck;
   end

   // watchdog
   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // scoreboard monitor: pairs each expected entry with an observed entry
   initial begin : monitor
      forever begin
         @(negedge clk);
         while (act_q.size() > 0 && exp_q.size() > 0) begin
            mon_a = act_q.pop_front();
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_cmp++;
            if (mon_a !== mon_e) begin
               n_bad++;
               $display("FAIL %s: got 0x%0h required 0x%0h", mon_n, mon_a, mon_e);
            end
         end
      end
   end

   // driver tasks
   task automatic push_exp(input string nm, input logic [W-1:0] e);
      name_q.push_back(nm);
      exp_q.push_back(e);
   endtask

   task automatic push_act(input logic [W-1:0] a);
      act_q.push_back(a);
   endtask

   task automatic chk_sb(input string nm, input logic e);
      push_exp(nm, {15'b0, e});
      push_act({15'b0, StableBlock});
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic tck_sync();
      @(negedge ijtag_tck);
      #1;
   endtask

   // One tck cycle: ce/se/si seen at the rising edge, ue at the following
   // falling edge; so is sampled just after that falling edge.
   task automatic scan_cyc(input logic ce, input logic se, input logic ue,
                           input logic si, output logic so_b);
      ijtag_ce = ce;
      ijtag_se = se;
      ijtag_ue = ue;
      ijtag_si = si;
      @(negedge ijtag_tck);
      #1;
      so_b = ijtag_so;
      ijtag_ce = 1'b0;
      ijtag_se = 1'b0;
      ijtag_ue = 1'b0;
   endtask

   // Capture (with SE also high), then 6 shifts and update with SIB open.
   // wr = {tdr[4:0], sib} to load; rd = {captured tdr[4:0], captured sib}.
   task automatic scan_dr(input logic [5:0] wr, output logic [5:0] rd);
      logic b;
      tck_sync();
      scan_cyc(1'b1, 1'b1, 1'b0, 1'b0, b);
      rd[0] = b;
      for (int k = 1; k <= 6; k++) begin
         scan_cyc(1'b0, 1'b1, (k == 6), wr[k-1], b);
         if (k <= 5) rd[k] = b;
      end
   endtask

   // stimulus
   initial begin : stim
      logic       b;
      logic [5:0] rd;

      ijtag_reset = 1'b0;
      ijtag_sel   = 1'b1;
      ijtag_si    = 1'b0;
      ijtag_ce    = 1'b0;
      ijtag_se    = 1'b0;
      ijtag_ue    = 1'b0;
      ctl         = 4'b0000;
      aux         = 1'b1;

      #30;
      chk_sb("reset_stable", 1'b0);
      push_exp("reset_so", 16'h0000);
      push_act({15'b0, ijtag_so});

      // Test 1: masks cleared, raw = aux = 1; filter asserts after edge 10
      @(negedge clk);
      ijtag_reset = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         clk_edge();
         chk_sb("t1_filter_latency", (k == 10));
      end
      tck_sync();
      scan_cyc(1'b1, 1'b0, 1'b0, 1'b0, b);
      push_exp("t1_sib_capture", 16'h0001);
      push_act({15'b0, b});

      // Test 2: open SIB, mask ctl0/ctl2, ctl2 low blocks readiness
      ctl = 4'b1011;
      tck_sync();
      scan_cyc(1'b0, 1'b1, 1'b1, 1'b1, b);
      scan_dr({5'b00101, 1'b1}, rd);
      repeat (4) clk_edge();
      chk_sb("t2_masked_block", 1'b0);
      @(negedge clk);
      ctl = 4'b1111;
      for (int k = 1; k <= 10; k++) begin
         clk_edge();
         chk_sb("t2_unblock_latency", (k == 10));
      end

      // Test 3: capture live controller status and bypass bit
      @(negedge clk);
      ctl = 4'b1001;
      repeat (5) clk_edge();
      scan_dr({5'b00101, 1'b1}, rd);
      push_exp("t3_capture", {10'b0, 6'b010010});
      push_act({10'b0, rd});

      // Test 4: aux drops for 2 clk cycles at cnt=5; full count restarts
      @(negedge clk);
      ctl = 4'b1111;
      for (int k = 1; k <= 19; k++) begin
         if (k == 8) begin
            @(negedge clk);
            aux = 1'b0;
         end
         if (k == 10) begin
            @(negedge clk);
            aux = 1'b1;
         end
         clk_edge();
         chk_sb("t4_filter_restart", (k == 19));
      end

      // Test 5: bypass on, StableBlock tracks raw combinationally
      scan_dr({5'b10101, 1'b1}, rd);
      push_exp("t5_capture", {10'b0, 6'b011111});
      push_act({10'b0, rd});
      #1;
      chk_sb("t5_bypass_high", 1'b1);
      aux = 1'b0;
      #1;
      chk_sb("t5_bypass_aux_low", 1'b0);
      aux = 1'b1;
      #1;
      chk_sb("t5_bypass_aux_high", 1'b1);
      ctl = 4'b1011;
      #1;
      chk_sb("t5_bypass_ctl2_low", 1'b0);
      ctl = 4'b1101;
      #1;
      chk_sb("t5_bypass_ctl1_unmasked", 1'b1);
      ctl = 4'b1111;

      // Test 6: all masks on, reset mid-count clears everything
      aux = 1'b0;
      scan_dr({5'b01111, 1'b1}, rd);
      repeat (5) clk_edge();
      @(negedge clk);
      aux = 1'b1;
      repeat (7) clk_edge();
      chk_sb("t6_midcount", 1'b0);
      ijtag_reset = 1'b0;
      #1;
      chk_sb("t6_reset_immediate", 1'b0);
      ctl = 4'b0000;
      #50;
      @(negedge clk);
      ijtag_reset = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         clk_edge();
         chk_sb("t6_masks_cleared", (k == 10));
      end
      tck_sync();
      scan_cyc(1'b0, 1'b1, 1'b0, 1'b1, b);
      push_exp("t6_sib_only_a", 16'h0001);
      push_act({15'b0, b});
      scan_cyc(1'b0, 1'b1, 1'b0, 1'b0, b);
      push_exp("t6_sib_only_b", 16'h0000);
      push_act({15'b0, b});
      scan_cyc(1'b0, 1'b1, 1'b0, 1'b1, b);
      push_exp("t6_sib_only_c", 16'h0001);
      push_act({15'b0, b});

      // final report
      repeat (3) clk_edge();
      if (exp_q.size() != 0 || act_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d/%0d entries left required 0/0",
                  exp_q.size(), act_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
